// File: rtl/carry_look_ahead_adder_pkg.sv
// Shared constants and helpers for the carry look-ahead adder.
//   CLA_GROUP_DEFAULT : default number of bits per first-level look-ahead group
//   num_groups()      : number of first-level groups, ceil(width / group)
package carry_look_ahead_adder_pkg;

    localparam int unsigned CLA_GROUP_DEFAULT = 4;

    function automatic int unsigned num_groups(input int unsigned width,
                                               input int unsigned group);
        return (width + group - 1) / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// First-level look-ahead group: an N-bit slice of the adder.
// Ports:
//   a_i, b_i : operand slices
//   c_i      : slice carry-in
//   s_o      : sum slice
//   gg_o     : group generate (slice produces a carry by itself)
//   gp_o     : group propagate (slice passes its carry-in through)
module cla_group
    import carry_look_ahead_adder_pkg::*;
#(
    parameter int unsigned N = CLA_GROUP_DEFAULT
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         gg_o,
    output logic         gp_o
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] carry;
    logic         term;

    // Each internal carry is built as a flat OR of product terms:
    //   carry[k] = c_i & p[0..k-1]  |  OR_j ( g[j] & p[j+1..k-1] )
    // so no carry depends on another carry inside the slice.
    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        carry = '0;
        gg_o  = 1'b0;
        term  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            term = c_i;
            for (int unsigned m = 0; m < k; m++) begin
                term = term & p[m];
            end
            carry[k] = term;
            for (int unsigned j = 0; j < k; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m < k; m++) begin
                    term = term & p[m];
                end
                carry[k] = carry[k] | term;
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m < N; m++) begin
                term = term & p[m];
            end
            gg_o = gg_o | term;
        end
        gp_o = &p;
        s_o  = p ^ carry;
    end

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry look-ahead adder: {c, s} = a + b + y.
// Ports:
//   clk      : clock for the registered outputs only
//   rst      : synchronous active-high reset of c_q/s_q
//   a, b     : unsigned operands
//   y        : carry-in
//   c, s     : combinational carry-out and sum
//   c_q, s_q : same result registered one cycle later
module carry_look_ahead_adder
    import carry_look_ahead_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned GROUP = CLA_GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             y,
    output logic             c,
    output logic [WIDTH-1:0] s,
    output logic             c_q,
    output logic [WIDTH-1:0] s_q
);

    localparam int unsigned NG = num_groups(WIDTH, GROUP);

    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic          term;
    logic          c_d;
    logic [WIDTH-1:0] s_d;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int unsigned LO = gi * GROUP;
        // Last slice is narrower when WIDTH is not a multiple of GROUP.
        localparam int unsigned N  = (WIDTH - LO < GROUP) ? (WIDTH - LO) : GROUP;

        cla_group #(
            .N (N)
        ) u_grp (
            .a_i  (a[LO +: N]),
            .b_i  (b[LO +: N]),
            .c_i  (gc[gi]),
            .s_o  (s[LO +: N]),
            .gg_o (gg[gi]),
            .gp_o (gp[gi])
        );
    end

    // Second level: group carry-ins in flat sum-of-products over GG/GP.
    always_comb begin
        gc   = '0;
        term = 1'b0;
        for (int unsigned k = 0; k <= NG; k++) begin
            term = y;
            for (int unsigned m = 0; m < k; m++) begin
                term = term & gp[m];
            end
            gc[k] = term;
            for (int unsigned j = 0; j < k; j++) begin
                term = gg[j];
                for (int unsigned m = j + 1; m < k; m++) begin
                    term = term & gp[m];
                end
                gc[k] = gc[k] | term;
            end
        end
    end

    assign c   = gc[NG];
    assign c_d = c;
    assign s_d = s;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            s_q <= '0;
        end else begin
            c_q <= c_d;
            s_q <= s_d;
        end
    end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
module tb_carry_look_ahead_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // WIDTH=3 instance (default GROUP)
    logic [2:0]  a3, b3, s3, s3_q;
    logic        y3, c3, c3_q;
    // WIDTH=1
    logic [0:0]  a1, b1, s1, s1_q;
    logic        y1, c1, c1_q;
    // WIDTH=8, GROUP=3 -> partial last group of 2
    logic [7:0]  a8, b8, s8, s8_q;
    logic        y8, c8, c8_q;
    // WIDTH=13 -> partial last group of 1
    logic [12:0] a13, b13, s13, s13_q;
    logic        y13, c13, c13_q;
    // WIDTH=32
    logic [31:0] a32, b32, s32, s32_q;
    logic        y32, c32, c32_q;

    carry_look_ahead_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .a(a3), .b(b3), .y(y3),
        .c(c3), .s(s3), .c_q(c3_q), .s_q(s3_q));
    carry_look_ahead_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1),
        .c(c1), .s(s1), .c_q(c1_q), .s_q(s1_q));
    carry_look_ahead_adder #(.WIDTH(8), .GROUP(3)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8),
        .c(c8), .s(s8), .c_q(c8_q), .s_q(s8_q));
    carry_look_ahead_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .y(y13),
        .c(c13), .s(s13), .c_q(c13_q), .s_q(s13_q));
    carry_look_ahead_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .y(y32),
        .c(c32), .s(s32), .c_q(c32_q), .s_q(s32_q));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, {carry, sum} of width w.
    function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] z,
                                            input logic ci);
        return x + z + 64'(ci);
    endfunction

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       y;
        logic [2:0] s;
        logic       c;
    } vec_t;

    vec_t tbl [6];
    logic [63:0] e3, e1, e8, e13, e32;

    initial begin
        tbl[0] = '{a:3'd7, b:3'd1, y:1'b0, s:3'd0, c:1'b1};
        tbl[1] = '{a:3'd5, b:3'd2, y:1'b0, s:3'd7, c:1'b0};
        tbl[2] = '{a:3'd5, b:3'd2, y:1'b1, s:3'd0, c:1'b1};
        tbl[3] = '{a:3'd7, b:3'd7, y:1'b1, s:3'd7, c:1'b1};
        tbl[4] = '{a:3'd0, b:3'd0, y:1'b0, s:3'd0, c:1'b0};
        tbl[5] = '{a:3'd3, b:3'd6, y:1'b1, s:3'd2, c:1'b1};

        a3 = '0; b3 = '0; y3 = 1'b0;
        a1 = '0; b1 = '0; y1 = 1'b0;
        a8 = '0; b8 = '0; y8 = 1'b0;
        a13 = '0; b13 = '0; y13 = 1'b0;
        a32 = '0; b32 = '0; y32 = 1'b0;

        // Reset held with a live sum on the inputs: registers stay clear.
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd1; y3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_c_q", 64'(c3_q), 64'd0);
            chk("rst_hold_s_q", 64'(s3_q), 64'd0);
            chk("rst_hold_c", 64'(c3), 64'd1);
            chk("rst_hold_s", 64'(s3), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_c_q", 64'(c3_q), 64'd1);
        chk("rst_release_s_q", 64'(s3_q), 64'd1);
        @(negedge clk);
        a3 = 3'd6; b3 = 3'd0; y3 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_c_q", 64'(c3_q), 64'd0);
        chk("rst_mid_s_q", 64'(s3_q), 64'd0);
        chk("rst_mid_s_comb", 64'(s3), 64'd6);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, combinational then registered.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a3 = tbl[i].a; b3 = tbl[i].b; y3 = tbl[i].y;
            #1;
            chk("tbl_s", 64'(s3), 64'(tbl[i].s));
            chk("tbl_c", 64'(c3), 64'(tbl[i].c));
            @(posedge clk); #1;
            chk("tbl_s_q", 64'(s3_q), 64'(tbl[i].s));
            chk("tbl_c_q", 64'(c3_q), 64'(tbl[i].c));
        end

        // Exhaustive WIDTH=3 sweep.
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int yi = 0; yi < 2; yi++) begin
                    @(negedge clk);
                    a3 = 3'(ai); b3 = 3'(bi); y3 = 1'(yi);
                    e3 = 64'(ai + bi + yi);
                    #1;
                    chk("sweep3_comb", 64'({c3, s3}), e3);
                    @(posedge clk); #1;
                    chk("sweep3_reg", 64'({c3_q, s3_q}), e3);
                end
            end
        end

        // Random vectors at the other widths.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a1 = 1'($urandom);  b1 = 1'($urandom);  y1 = 1'($urandom);
            a8 = 8'($urandom);  b8 = 8'($urandom);  y8 = 1'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom); y13 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; y32 = 1'($urandom);
            if (n < 8) begin
                // Boundary: all-ones operands and full propagate chains.
                a32 = '1; b32 = (n < 4) ? '1 : '0; y32 = n[0];
                a13 = '1; b13 = (n < 4) ? '1 : '0; y13 = n[0];
                a8  = 8'h5A; b8 = 8'hA5; y8 = n[0];
            end
            e1  = ref_add(64'(a1), 64'(b1), y1);
            e8  = ref_add(64'(a8), 64'(b8), y8);
            e13 = ref_add(64'(a13), 64'(b13), y13);
            e32 = ref_add(64'(a32), 64'(b32), y32);
            #1;
            chk("rand1_comb", 64'({c1, s1}), e1);
            chk("rand8_comb", 64'({c8, s8}), e8);
            chk("rand13_comb", 64'({c13, s13}), e13);
            chk("rand32_comb", 64'({c32, s32}), e32);
            @(posedge clk); #1;
            chk("rand1_reg", 64'({c1_q, s1_q}), e1);
            chk("rand8_reg", 64'({c8_q, s8_q}), e8);
            chk("rand13_reg", 64'({c13_q, s13_q}), e13);
            chk("rand32_reg", 64'({c32_q, s32_q}), e32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
